// File: rtl/bram_reduce_pkg.sv
// Shared encodings for the bram_reduce block: reduction modes, FSM states
// and pl_status bit positions.
package bram_reduce_pkg;

  typedef enum logic [2:0] {
    MODE_MAXU = 3'b000,
    MODE_MAXS = 3'b001,
    MODE_MINU = 3'b010,
    MODE_MINS = 3'b011,
    MODE_SUM  = 3'b100
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_WRITE_IDX,
    S_DONE
  } state_e;

  localparam int unsigned ST_DONE    = 0;
  localparam int unsigned ST_BUSY    = 1;
  localparam int unsigned ST_ERR     = 2;
  localparam int unsigned ST_IDX_LSB = 16;
  localparam int unsigned ST_IDX_W   = 16;

  // Modes 101..111 are reserved and rejected in CHECK.
  function automatic logic mode_legal(input logic [2:0] m);
    return (m <= MODE_SUM);
  endfunction

endpackage

// File: rtl/bram_reduce_if.sv
// PS register and BRAM port-B signal bundle for bram_reduce.
// slave: the reduction engine; master: the PS/BRAM environment.
interface bram_reduce_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2048,
  parameter int LEN_WIDTH  = 16
);
  localparam int ADDR_WIDTH = $clog2(DEPTH) + 2;

  logic [31:0]           ps_control;
  logic [ADDR_WIDTH-1:0] ps_base;
  logic [LEN_WIDTH-1:0]  ps_len;
  logic [ADDR_WIDTH-1:0] ps_dest;
  logic [31:0]           pl_status;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_wrdata;
  logic [DATA_WIDTH-1:0] bram_rddata;
  logic [3:0]            bram_we;

  modport slave (
    input  ps_control, ps_base, ps_len, ps_dest, bram_rddata,
    output pl_status, bram_addr, bram_wrdata, bram_we
  );

  modport master (
    output ps_control, ps_base, ps_len, ps_dest, bram_rddata,
    input  pl_status, bram_addr, bram_wrdata, bram_we
  );
endinterface

// File: rtl/bram_reduce_alu.sv
// Combinational reduction step: folds one data word into the accumulator.
// take_o marks a strictly better max/min candidate (ties keep the earlier word).
module bram_reduce_alu
  import bram_reduce_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] next_acc_o,
  output logic                  take_o
);

  // Compare or add according to mode; illegal modes leave acc unchanged.
  always_comb begin
    take_o     = 1'b0;
    next_acc_o = acc_i;
    case (mode_i)
      MODE_MAXU: take_o = (data_i > acc_i);
      MODE_MAXS: take_o = ($signed(data_i) > $signed(acc_i));
      MODE_MINU: take_o = (data_i < acc_i);
      MODE_MINS: take_o = ($signed(data_i) < $signed(acc_i));
      MODE_SUM:  next_acc_o = acc_i + data_i;
      default:   ;
    endcase
    if (take_o) next_acc_o = data_i;
  end

endmodule

// File: rtl/bram_reduce.sv
// bram_reduce: streams a BRAM window through port B, reduces it (max/min/sum)
// and writes the result back. Optional macro BRAM_REDUCE_INDEX_EN adds
// winning-offset tracking, a status field and a second result write.
module bram_reduce
  import bram_reduce_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2048,
  parameter int LEN_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         reset,
  bram_reduce_if.slave bus
);

  localparam int ADDR_WIDTH = $clog2(DEPTH) + 2;
  localparam int IW         = ADDR_WIDTH - 2;
  localparam int EW         = LEN_WIDTH + ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [2:0]            mode_q;
  logic [IW-1:0]         base_q, dest_q;
  logic [LEN_WIDTH-1:0]  len_q, cnt_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] acc_q, acc_init;
  logic                  err_q;
  logic                  start, cfg_err, last_issue, alu_take;
  logic [DATA_WIDTH-1:0] alu_acc;
  logic [IW-1:0]         rd_idx;
  logic                  unused_cfg;
`ifdef BRAM_REDUCE_INDEX_EN
  logic [LEN_WIDTH-1:0]  off_q, idx_q;
`endif

  assign start      = bus.ps_control[0];
  assign rd_idx     = base_q + IW'(cnt_q);
  assign last_issue = (cnt_q == len_q - LEN_WIDTH'(1));
  assign unused_cfg = ^{bus.ps_control[31:4], bus.ps_base[1:0], bus.ps_dest[1:0]};

  bram_reduce_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .mode_i     (mode_q),
    .acc_i      (acc_q),
    .data_i     (bus.bram_rddata),
    .next_acc_o (alu_acc),
    .take_o     (alu_take)
  );

  // Job validation on the latched configuration (window end checked unwrapped).
  always_comb begin
    cfg_err = !mode_legal(mode_q) || (len_q == '0)
           || (EW'(base_q) + EW'(len_q) > EW'(DEPTH))
           || ((IW+1)'(dest_q) >= (IW+1)'(DEPTH));
`ifdef BRAM_REDUCE_INDEX_EN
    cfg_err = cfg_err || ((IW+1)'(dest_q) + (IW+1)'(1) >= (IW+1)'(DEPTH));
`endif
  end

  // Identity element of the selected reduction.
  always_comb begin
    acc_init = '0;
    case (mode_q)
      MODE_MAXS: acc_init[DATA_WIDTH-1] = 1'b1;
      MODE_MINU: acc_init = '1;
      MODE_MINS: begin
        acc_init = '1;
        acc_init[DATA_WIDTH-1] = 1'b0;
      end
      default: acc_init = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: state_d = cfg_err ? S_DONE : S_READ;
      S_READ:  if (last_issue) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WRITE;
`ifdef BRAM_REDUCE_INDEX_EN
      S_WRITE:     state_d = S_WRITE_IDX;
      S_WRITE_IDX: state_d = S_DONE;
`else
      S_WRITE:     state_d = S_DONE;
`endif
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Port-B drive decoded from state so write enable falls with reset at once.
  always_comb begin
    bus.bram_addr   = '0;
    bus.bram_wrdata = '0;
    bus.bram_we     = '0;
    case (state_q)
      S_READ:  bus.bram_addr = {rd_idx, 2'b00};
      S_WRITE: begin
        bus.bram_addr   = {dest_q, 2'b00};
        bus.bram_wrdata = acc_q;
        bus.bram_we     = '1;
      end
`ifdef BRAM_REDUCE_INDEX_EN
      S_WRITE_IDX: begin
        bus.bram_addr   = {dest_q + IW'(1), 2'b00};
        bus.bram_wrdata = DATA_WIDTH'(idx_q);
        bus.bram_we     = '1;
      end
`endif
      default: ;
    endcase
  end

  // Status word; only meaningful fields are shown while in DONE.
  always_comb begin
    bus.pl_status          = '0;
    bus.pl_status[ST_DONE] = (state_q == S_DONE);
    bus.pl_status[ST_ERR]  = err_q && (state_q == S_DONE);
    bus.pl_status[ST_BUSY] = state_q inside {S_CHECK, S_READ, S_DRAIN, S_WRITE, S_WRITE_IDX};
`ifdef BRAM_REDUCE_INDEX_EN
    if (state_q == S_DONE) bus.pl_status[ST_IDX_LSB +: ST_IDX_W] = ST_IDX_W'(idx_q);
`endif
  end

  // Config capture, read sequencing and accumulation (data lands one cycle after issue).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q     <= '0;
      base_q     <= '0;
      len_q      <= '0;
      dest_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      acc_q      <= '0;
      err_q      <= 1'b0;
`ifdef BRAM_REDUCE_INDEX_EN
      off_q      <= '0;
      idx_q      <= '0;
`endif
    end else begin
      rd_valid_q <= (state_q == S_READ);
`ifdef BRAM_REDUCE_INDEX_EN
      off_q      <= cnt_q;
`endif
      case (state_q)
        S_IDLE: begin
          err_q <= 1'b0;
          if (start) begin
            mode_q <= bus.ps_control[3:1];
            base_q <= bus.ps_base[ADDR_WIDTH-1:2];
            len_q  <= bus.ps_len;
            dest_q <= bus.ps_dest[ADDR_WIDTH-1:2];
          end
        end
        S_CHECK: begin
          err_q <= cfg_err;
          acc_q <= acc_init;
          cnt_q <= '0;
`ifdef BRAM_REDUCE_INDEX_EN
          idx_q <= '0;
`endif
        end
        S_READ:  cnt_q <= cnt_q + LEN_WIDTH'(1);
        default: ;
      endcase
      if (rd_valid_q) begin
        acc_q <= alu_acc;
`ifdef BRAM_REDUCE_INDEX_EN
        if (alu_take) idx_q <= off_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bram_reduce.sv
// Self-checking bench for bram_reduce: table of directed jobs, full-depth
// job, reset-during-read, start held through DONE, and randomized jobs
// against a behavioural reduction model over the bench's BRAM array.
module tb_bram_reduce;
  import bram_reduce_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 2048;
  localparam int LW    = 16;
  localparam int AW    = $clog2(DEPTH) + 2;
`ifdef BRAM_REDUCE_INDEX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bram_reduce_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_WIDTH(LW)) bus ();
  bram_reduce #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Port-B BRAM model: registered read, full-word write.
  logic [31:0] mem [DEPTH];
  int wr_cnt = 0;
  int bad_we = 0;
  always @(posedge clk) begin
    bus.bram_rddata <= mem[bus.bram_addr[AW-1:2]];
    if (bus.bram_we != 4'h0) wr_cnt++;
    if (bus.bram_we != 4'h0 && bus.bram_we != 4'hf) bad_we++;
    if (bus.bram_we == 4'hf) mem[bus.bram_addr[AW-1:2]] = bus.bram_wrdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Reference: reduce the window with plain arithmetic, first winner kept.
  function automatic void model(input int b, input int l, input int d, input int m,
                                output bit err, output logic [31:0] res, output int idx);
    logic [31:0] w;
    bit better;
    err = (m > 4) || (l == 0) || (b + l > DEPTH) || (d >= DEPTH) || (IDX_EN && d + 1 >= DEPTH);
    res = 32'h0;
    idx = 0;
    if (err) return;
    res = mem[b];
    for (int k = 1; k < l; k++) begin
      w = mem[b + k];
      case (m)
        0:       better = (w > res);
        1:       better = ($signed(w) > $signed(res));
        2:       better = (w < res);
        3:       better = ($signed(w) < $signed(res));
        default: better = 1'b0;
      endcase
      if (m == 4) res = res + w;
      else if (better) begin
        res = w;
        idx = k;
      end
    end
  endfunction

  task automatic start_job(input int base_b, input int len, input int dest_b, input int mode);
    @(negedge clk);
    bus.ps_base    = AW'(base_b);
    bus.ps_len     = LW'(len);
    bus.ps_dest    = AW'(dest_b);
    bus.ps_control = {28'($urandom), 3'(mode), 1'b1};
  endtask

  task automatic wait_done(output int cyc, output logic [31:0] st);
    @(posedge clk);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.pl_status[ST_DONE] && cyc < 5000);
    st = bus.pl_status;
    if (!bus.pl_status[ST_DONE]) chk("done_timeout", 64'(cyc), 64'(0));
  endtask

  task automatic release_start(input string nm);
    @(negedge clk);
    bus.ps_control[0] = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_idle_status"}, 64'(bus.pl_status), 64'h0);
  endtask

  task automatic check_result(input string nm, input int len, input int dest_idx, input bit exp_err,
                              input logic [31:0] exp_res, input int exp_idx, input int cyc,
                              input logic [31:0] st, input int wr0, input logic [31:0] old_dest);
    logic [31:0] exp_st;
    int di;
    di = dest_idx % DEPTH;
    exp_st = {(IDX_EN && !exp_err) ? 16'(exp_idx) : 16'h0, 13'h0, exp_err, 1'b0, 1'b1};
    chk({nm, "_status"}, 64'(st), 64'(exp_st));
    if (!exp_err) begin
      chk({nm, "_latency"}, 64'(cyc), 64'(len + 3 + int'(IDX_EN)));
      chk({nm, "_result"}, 64'(mem[di]), 64'(exp_res));
      chk({nm, "_writes"}, 64'(wr_cnt - wr0), 64'(1 + int'(IDX_EN)));
      if (IDX_EN) chk({nm, "_idx_word"}, 64'(mem[(di + 1) % DEPTH]), 64'(exp_idx));
    end else begin
      chk({nm, "_writes"}, 64'(wr_cnt - wr0), 64'h0);
      chk({nm, "_dest_kept"}, 64'(mem[di]), 64'(old_dest));
    end
  endtask

  task automatic run_job(input string nm, input int base_idx, input int len, input int dest_idx,
                         input int mode, input int lowbits, input bit exp_err,
                         input logic [31:0] exp_res, input int exp_idx);
    int cyc, wr0;
    logic [31:0] st, old_dest;
    old_dest = mem[dest_idx % DEPTH];
    wr0 = wr_cnt;
    start_job(base_idx * 4 + lowbits, len, dest_idx * 4 + lowbits, mode);
    wait_done(cyc, st);
    check_result(nm, len, dest_idx, exp_err, exp_res, exp_idx, cyc, st, wr0, old_dest);
    release_start(nm);
  endtask

  typedef struct {
    string       nm;
    int          base_idx;
    int          len;
    int          dest_idx;
    int          mode;
    int          lowbits;
    bit          err;
    logic [31:0] res;
    int          idx;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [31:0] pick_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc, wr0, stay_bad, ridx;
    bit rerr;
    logic [31:0] st, rres, hold_st;

    vecs[0]  = '{"bound_sum", 2045, 3, 500, 4, 0, 1'b0, 32'd6, 0};
    vecs[1]  = '{"mins",      10, 4, 100, 3, 0, 1'b0, 32'hFFFF_FFFD, 1};
    vecs[2]  = '{"maxs",      10, 4, 100, 1, 3, 1'b0, 32'd7, 3};
    vecs[3]  = '{"maxu",      10, 4, 100, 0, 0, 1'b0, 32'hFFFF_FFFD, 1};
    vecs[4]  = '{"minu",      10, 4, 102, 2, 0, 1'b0, 32'd5, 0};
    vecs[5]  = '{"sum_wrap",  20, 3, 104, 4, 0, 1'b0, 32'd2, 0};
    vecs[6]  = '{"len0",      10, 0, 106, 0, 0, 1'b1, 32'd0, 0};
    vecs[7]  = '{"base_oob",  2046, 3, 108, 4, 0, 1'b1, 32'd0, 0};
    vecs[8]  = '{"mode6",     10, 4, 110, 6, 0, 1'b1, 32'd0, 0};
    vecs[9]  = '{"mode5",     10, 4, 110, 5, 0, 1'b1, 32'd0, 0};
    vecs[10] = '{"dest_last", 20, 3, 2047, 4, 0, IDX_EN, 32'd2, 0};
    vecs[11] = '{"len1",      13, 1, 112, 3, 0, 1'b0, 32'd7, 0};

    reset          = 1'b0;
    bus.ps_control = '0;
    bus.ps_base    = '0;
    bus.ps_len     = '0;
    bus.ps_dest    = '0;
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'h0;
    #1;
    chk("rst_status", 64'(bus.pl_status), 64'h0);
    chk("rst_we", 64'(bus.bram_we), 64'h0);
    chk("rst_addr", 64'(bus.bram_addr), 64'h0);
    chk("rst_wrdata", 64'(bus.bram_wrdata), 64'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Full-depth unsigned max with a single large outlier.
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'(k);
    mem[37] = 32'hFFFF_FFF0;
    run_job("full", 0, 2048, 0, 0, 0, 1'b0, 32'hFFFF_FFF0, 37);

    mem[10] = 32'd5; mem[11] = 32'hFFFF_FFFD; mem[12] = 32'hFFFF_FFFD; mem[13] = 32'd7;
    mem[20] = 32'hFFFF_FFFF; mem[21] = 32'd2; mem[22] = 32'd1;
    mem[2045] = 32'd1; mem[2046] = 32'd2; mem[2047] = 32'd3;
    for (int i = 0; i < 12; i++)
      run_job(vecs[i].nm, vecs[i].base_idx, vecs[i].len, vecs[i].dest_idx, vecs[i].mode,
              vecs[i].lowbits, vecs[i].err, vecs[i].res, vecs[i].idx);

    // Reset during READ (offset 5 of 100), then rerun with start still held.
    for (int k = 1000; k < 1100; k++) mem[k] = pick_word();
    model(1000, 100, 1200, 4, rerr, rres, ridx);
    start_job(4000, 100, 4800, 4);
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    chk("midread_busy", 64'(bus.pl_status), 64'h2);
    wr0 = wr_cnt;
    reset = 1'b0;
    #1;
    chk("midread_rst_we", 64'(bus.bram_we), 64'h0);
    chk("midread_rst_status", 64'(bus.pl_status), 64'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_done(cyc, st);
    check_result("rerun", 100, 1200, rerr, rres, ridx, cyc, st, wr0, 32'h0);

    // Start held through DONE must not retrigger.
    hold_st = bus.pl_status;
    wr0 = wr_cnt;
    stay_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus.pl_status !== hold_st) stay_bad++;
    end
    chk("hold_stays_done", 64'(stay_bad), 64'h0);
    chk("hold_no_write", 64'(wr_cnt - wr0), 64'h0);
    release_start("hold");
    run_job("second", 10, 4, 120, 3, 0, 1'b0, 32'hFFFF_FFFD, 1);

    // Randomized jobs against the model.
    for (int n = 0; n < 25; n++) begin
      int b, l, d, m;
      b = $urandom_range(0, DEPTH - 1);
      l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
      d = $urandom_range(0, DEPTH - 1);
      m = $urandom_range(0, 5);
      for (int k = 0; k < l; k++) if (b + k < DEPTH) mem[b + k] = pick_word();
      model(b, l, d, m, rerr, rres, ridx);
      run_job($sformatf("rand%0d", n), b, l, d, m, int'($urandom_range(0, 3)), rerr, rres, ridx);
    end

    chk("we_encoding", 64'(bad_we), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
